tic_computer_move_gen: RTL and testbench
========================================

// Module: tic_computer_move_gen
// PURPOSE
//  Computer opponent for the tic-tac-toe datapath. On a start request it snapshots the 9-cell board,
//  then searches it in a fixed priority: win, block, centre, corner, edge. It returns a cell index
//  on computer_position with a one-cycle pc strobe. This block drives the computer_position/pc inputs
//  of the game top, whose controller waits in its COMPUTER state until pc is asserted.
// PARAMETERS
//  none; the line table and priority order are fixed constants.
// PORTS
//  clock              in   1  single clock, rising edge
//  reset              in   1  asynchronous, active-low reset: 0 = reset
//  start              in   1  request a move; sampled only in IDLE
//  pos1..pos9         in   2  board cells, one port each; 00 empty, 01 player, 10 computer, 11 occupied/neither
//  computer_position  out  4  chosen cell index, 0..8 = pos1..pos9; registered
//  pc                 out  1  one-cycle strobe: computer_position is valid
//  no_move            out  1  one-cycle strobe: no empty cell found
//  busy               out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, computer_position=0, pc=0, no_move=0, busy=0, snapshot=all 00.
//   Reset mid-search aborts the search immediately; no strobe is issued.
//  States: IDLE -> SNAP -> SCAN_WIN -> SCAN_BLOCK -> CHK_CENTER -> SCAN_FREE -> DONE/NOMOVE -> IDLE.
//  Edge numbering: E0 is the edge at which start=1 is sampled in IDLE.
//  IDLE: start=1 -> SNAP. start while busy is ignored; it is not queued.
//  SNAP: latch pos1..pos9 into an 18-bit snapshot; the live board is ignored until the next SNAP.
//  SCAN_WIN: 3-bit line counter L=0..7, evaluating one line per cycle at edges E2..E9.
//   Lines: 0(0,1,2) 1(3,4,5) 2(6,7,8) 3(0,3,6) 4(1,4,7) 5(2,5,8) 6(0,4,8) 7(2,4,6).
//   Hit = exactly two cells 10 and one cell 00. On the first hit, computer_position=empty cell -> DONE.
//   After L=7 with no hit: reset L to 0 -> SCAN_BLOCK.
//  SCAN_BLOCK: same as SCAN_WIN with mark 01; evaluated at edges E10..E17.
//  CHK_CENTER: evaluated at E18. Cell 4 == 00 -> computer_position=4 -> DONE; else -> SCAN_FREE.
//  SCAN_FREE: 3-bit index I over the order 0,2,6,8,1,3,5,7, one cell per cycle at E19..E26.
//   The first 00 cell -> DONE. If I=7 has no hit -> NOMOVE.
//  DONE: pc=1 for exactly one cycle, then -> IDLE.
//  NOMOVE: no_move=1 for exactly one cycle; computer_position unchanged; then -> IDLE.
//  Latency (E0 to the strobe cycle): win on line L = L+2; block on line L = L+10; centre = 18;
//   free cell at order index I = I+19; no_move = 26.
//  computer_position holds its value between results; it changes only on the edge that enters DONE.
//  pc and no_move are never both 1. busy=0 during the strobe cycle's successor (IDLE).
//  Cell 11 counts as neither empty nor a mark in any test.
//  A line with two computer cells and one 11 cell is not a hit.
// STRUCTURE
//  Shared package/include tic_defs: cell codes (EMPTY=2'b00, PLAYER=2'b01, COMP=2'b10),
//   the 8x3 line table, the free-cell priority table, and FSM state encodings (3 bits).
//  Sub-module tic_line_eval (combinational): inputs c0,c1,c2[1:0] and mark[1:0];
//   outputs hit and empty_sel[1:0]. One instance is shared by SCAN_WIN and SCAN_BLOCK, with mark muxed by state.
//  Single always block for the state register and counters; all outputs are registered.
// TESTING
//  1 Empty board, start at E0 -> pc=1 in the cycle after E18, computer_position=4, no_move=0.
//  2 Cells 0,1 = 10, all others 00 -> pc after E2, position=2. The win beats the block of player 3,4 = 01.
//  3 Cells 3,4 = 01, 0 = 10, all others 00 -> no win, block on line 1 -> pc after E11, position=5.
//  4 Full board with no lines -> no_move=1 after E26, pc never 1; computer_position keeps its prior value.
//  5 Change pos1..pos9 and pulse start during a search -> result matches the E1 snapshot; the extra start is ignored.
//  6 Reset driven to 0 at E5 of a search -> all outputs 0 asynchronously; after release, start -> normal result.

Source files
------------

// File: rtl/tic_computer_move_gen_pkg.sv
// tic_computer_move_gen_pkg: cell codes, line and free-cell tables, FSM state encoding
package tic_computer_move_gen_pkg;
  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] PLAYER = 2'b01;
  localparam logic [1:0] COMP   = 2'b10;
  // Three board cells per line: rows, then columns, then the two diagonals
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  // Corners are preferred over edges when no tactical move exists
  localparam logic [3:0] FREE_ORDER [8] = '{
    4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };
  typedef enum logic [2:0] {
    IDLE, SNAP, SCAN_WIN, SCAN_BLOCK, CHK_CENTER, SCAN_FREE, DONE, NOMOVE
  } state_t;
endpackage

// File: rtl/tic_computer_move_gen_line_eval.sv
// tic_computer_move_gen_line_eval: flags a line holding two marks and one empty cell
module tic_computer_move_gen_line_eval
  import tic_computer_move_gen_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] empty_sel
);
  logic [1:0] n_mark;
  logic [1:0] n_empty;
  // Count marks and empties; a blocked (11) cell counts as neither
  always_comb begin
    n_mark    = 2'(c0 == mark) + 2'(c1 == mark) + 2'(c2 == mark);
    n_empty   = 2'(c0 == EMPTY) + 2'(c1 == EMPTY) + 2'(c2 == EMPTY);
    hit       = (n_mark == 2'd2) && (n_empty == 2'd1);
    empty_sel = (c0 == EMPTY) ? 2'd0 : (c1 == EMPTY) ? 2'd1 : 2'd2;
  end
endmodule

// File: rtl/tic_computer_move_gen.sv
// tic_computer_move_gen: sequential win/block/centre/corner/edge move search on a board snapshot
module tic_computer_move_gen
  import tic_computer_move_gen_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       no_move,
  output logic       busy
);
  state_t           state;
  logic [8:0][1:0]  snap;
  logic [2:0]       line;
  logic [2:0]       idx;
  logic [1:0]       mark;
  logic             hit;
  logic [1:0]       empty_sel;
  logic [3:0]       sel_cell;
  logic [3:0]       free_cell;
  logic             free_hit;
  // One evaluator serves both line scans; only the mark being counted differs
  always_comb begin
    mark      = (state == SCAN_BLOCK) ? PLAYER : COMP;
    sel_cell  = LINE_TBL[line][empty_sel];
    free_cell = FREE_ORDER[idx];
    free_hit  = snap[free_cell] == EMPTY;
  end
  tic_computer_move_gen_line_eval u_eval (
    .c0        (snap[LINE_TBL[line][0]]),
    .c1        (snap[LINE_TBL[line][1]]),
    .c2        (snap[LINE_TBL[line][2]]),
    .mark      (mark),
    .hit       (hit),
    .empty_sel (empty_sel)
  );
  // Search FSM with counters; strobes are set on the edge entering DONE/NOMOVE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      snap              <= '0;
      line              <= '0;
      idx               <= '0;
      computer_position <= '0;
      pc                <= 1'b0;
      no_move           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      pc      <= 1'b0;
      no_move <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SNAP;
          busy  <= 1'b1;
        end
        SNAP: begin
          snap  <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
          line  <= '0;
          state <= SCAN_WIN;
        end
        SCAN_WIN, SCAN_BLOCK: if (hit) begin
          computer_position <= sel_cell;
          pc                <= 1'b1;
          state             <= DONE;
        end else begin
          line <= line + 3'd1;
          if (line == 3'd7) state <= (state == SCAN_WIN) ? SCAN_BLOCK : CHK_CENTER;
        end
        CHK_CENTER: if (snap[4] == EMPTY) begin
          computer_position <= 4'd4;
          pc                <= 1'b1;
          state             <= DONE;
        end else begin
          idx   <= '0;
          state <= SCAN_FREE;
        end
        SCAN_FREE: if (free_hit) begin
          computer_position <= free_cell;
          pc                <= 1'b1;
          state             <= DONE;
        end else begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            no_move <= 1'b1;
            state   <= NOMOVE;
          end
        end
        DONE, NOMOVE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tic_computer_move_gen.sv
// tb_tic_computer_move_gen: directed scenarios checking move choice, latency and strobes
module tb_tic_computer_move_gen;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] b [9];
  logic [3:0] computer_position;
  logic       pc, no_move, busy;
  int         total = 0;
  int         bad = 0;

  always #5 clock = ~clock;

  tic_computer_move_gen dut (
    .clock(clock), .reset(reset), .start(start),
    .pos1(b[0]), .pos2(b[1]), .pos3(b[2]), .pos4(b[3]), .pos5(b[4]),
    .pos6(b[5]), .pos7(b[6]), .pos8(b[7]), .pos9(b[8]),
    .computer_position(computer_position), .pc(pc), .no_move(no_move), .busy(busy)
  );

  task automatic set_board(input logic [1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8);
    b[0] = v0; b[1] = v1; b[2] = v2; b[3] = v3; b[4] = v4;
    b[5] = v5; b[6] = v6; b[7] = v7; b[8] = v8;
  endtask

  // Pulse start so the next rising edge is E0; return the edge index of the first strobe
  task automatic launch(output int lat, output logic spc, output logic snm);
    lat = -1; spc = 1'b0; snm = 1'b0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pc || no_move) begin
        lat = k; spc = pc; snm = no_move;
        break;
      end
    end
  endtask

  task automatic test_reset;
    set_board(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({computer_position, pc, no_move, busy} !== 7'd0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0000000", {computer_position, pc, no_move, busy});
    end
    @(negedge clock); reset = 1'b1;
  endtask

  // Common result check: latency, strobe kind, position, then single-cycle strobe and idle
  task automatic expect_move(input string name, input int exp_lat, input logic exp_pc, input logic [3:0] exp_pos);
    int lat; logic spc, snm;
    launch(lat, spc, snm);
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    total++;
    if ({spc, snm} !== {exp_pc, ~exp_pc}) begin bad++; $display("FAIL %s_strobe got pc=%b no_move=%b exp pc=%b", name, spc, snm, exp_pc); end
    total++;
    if (computer_position !== exp_pos) begin bad++; $display("FAIL %s_position got=%0d exp=%0d", name, computer_position, exp_pos); end
    @(posedge clock); #1;
    total++;
    if ({pc, no_move, busy} !== 3'b000) begin bad++; $display("FAIL %s_after got pc/no_move/busy=%b exp=000", name, {pc, no_move, busy}); end
  endtask

  task automatic test_center;
    set_board(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_move("center", 18, 1'b1, 4'd4);
  endtask

  task automatic test_win_over_block;
    set_board(2, 2, 0, 1, 1, 0, 0, 0, 0);
    expect_move("win", 2, 1'b1, 4'd2);
  endtask

  task automatic test_block;
    set_board(2, 0, 0, 1, 1, 0, 0, 0, 0);
    expect_move("block", 11, 1'b1, 4'd5);
  endtask

  task automatic test_no_move;
    set_board(2, 1, 2, 2, 1, 1, 1, 2, 2);
    expect_move("nomove", 26, 1'b0, 4'd5);
  endtask

  task automatic test_blocked_cell;
    set_board(2, 2, 3, 0, 0, 0, 0, 0, 0);
    expect_move("blocked11", 18, 1'b1, 4'd4);
  endtask

  task automatic test_free_edge;
    set_board(3, 0, 3, 0, 3, 0, 3, 0, 3);
    expect_move("free_edge", 23, 1'b1, 4'd1);
  endtask

  task automatic test_late_win;
    set_board(0, 0, 2, 0, 2, 0, 0, 0, 0);
    expect_move("win_line7", 9, 1'b1, 4'd6);
  endtask

  task automatic test_snapshot;
    int lat;
    int busy_seen;
    lat = -1; busy_seen = 0;
    set_board(0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pc || no_move) begin lat = k; break; end
      if (k == 3) set_board(2, 2, 0, 0, 0, 0, 0, 0, 0);
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
    end
    total++;
    if (lat !== 19) begin bad++; $display("FAIL snapshot_latency got=%0d exp=19", lat); end
    total++;
    if (computer_position !== 4'd0) begin bad++; $display("FAIL snapshot_position got=%0d exp=0", computer_position); end
    repeat (4) begin
      @(posedge clock); #1;
      if (busy || pc) busy_seen++;
    end
    total++;
    if (busy_seen !== 0) begin bad++; $display("FAIL snapshot_start_queued got=%0d busy cycles exp=0", busy_seen); end
  endtask

  task automatic test_mid_reset;
    set_board(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b exp=1", busy); end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({computer_position, pc, no_move, busy} !== 7'd0) begin
      bad++; $display("FAIL midreset_async got=%b exp=0000000", {computer_position, pc, no_move, busy});
    end
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    #1;
    total++;
    if ({pc, busy} !== 2'b00) begin bad++; $display("FAIL midreset_release got pc/busy=%b exp=00", {pc, busy}); end
  endtask

  initial begin
    test_reset;
    test_center;
    test_win_over_block;
    test_block;
    test_no_move;
    test_mid_reset;
    test_late_win;
    test_snapshot;
    test_blocked_cell;
    test_free_edge;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
